// File: rtl/seg_pkg.sv
// Shared types and constants for the NumbLock 7-segment scan path.
package seg_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_RAW_IDLE = 7'h7F;
  localparam int DIG_MAX = 32;

  typedef enum logic [1:0] {OFF, LOAD, SHOW, BLANK} scan_state_t;

  // Active-low one-hot digit enable; callers slice to their digit count.
  function automatic logic [DIG_MAX-1:0] dig_sel_n(input int unsigned idx);
    dig_sel_n = ~(DIG_MAX'(1) << idx);
  endfunction
endpackage

// File: rtl/seg_blink_gen.sv
// Free-running blink phase generator; phase toggles every BLINK_DIV cycles.
module seg_blink_gen
  import seg_pkg::*;
#(
  parameter int BLINK_DIV = 12500000
) (
  input  logic clk,
  input  logic rst,
  output logic blink_phase
);
  localparam int BW = $clog2(BLINK_DIV);

  logic [BW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      blink_phase <= 1'b0;
    end else if (cnt == BW'(BLINK_DIV - 1)) begin
      cnt         <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner: per-digit pattern store, blank gap between
// slots and per-digit blinking; seg_raw feeds the shared segment remapper.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_DIV    = 12500000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(DIGITS)-1:0]  wr_addr,
  input  logic [6:0]                 wr_data,
  input  logic                       wr_blink,
  output logic [6:0]                 seg_raw,
  output logic [DIGITS-1:0]          dig_sel,
  output logic [$clog2(DIGITS)-1:0]  cur_digit
);
  localparam int AW      = $clog2(DIGITS);
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  scan_state_t       state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              hide;
  logic              blink_phase;
  logic [SEG_W-1:0]  pat [DIGITS];
  logic [DIGITS-1:0] blink;
  logic              show_last, blank_last, wr_fire;
  logic [DIG_MAX-1:0] sel_full;

  assign show_last  = (cnt == CW'(SCAN_DIV - 1));
  assign blank_last = (cnt == CW'(BLANK_CYCLES - 1));
  assign wr_fire    = wr_valid & wr_ready;

  seg_blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk         (clk),
    .rst         (rst),
    .blink_phase (blink_phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OFF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = OFF;
    end else begin
      case (state)
        OFF:     state_nxt = LOAD;
        LOAD:    state_nxt = SHOW;
        SHOW:    if (show_last)  state_nxt = BLANK;
        BLANK:   if (blank_last) state_nxt = LOAD;
        default: state_nxt = OFF;
      endcase
    end
  end

  // rst gates wr_ready directly so it reads 0 for the whole reset interval.
  always_comb begin
    sel_full = '1;
    if (state == SHOW && !hide) sel_full = dig_sel_n(32'(cur_digit));
    dig_sel  = sel_full[DIGITS-1:0];
    wr_ready = (state != LOAD) && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      cur_digit <= '0;
      seg_raw   <= SEG_RAW_IDLE;
      hide      <= 1'b0;
    end else begin
      if ((state == SHOW || state == BLANK) && state_nxt == state) cnt <= cnt + 1'b1;
      else                                                       cnt <= '0;
      // Latching once per slot keeps seg_raw stable even if the lit digit is rewritten.
      if (state == LOAD && en) begin
        seg_raw <= pat[cur_digit];
        hide    <= blink[cur_digit] & blink_phase;
      end
      if (state == BLANK && en && blank_last)
        cur_digit <= (cur_digit == AW'(DIGITS - 1)) ? '0 : cur_digit + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DIGITS; i++) pat[i] <= SEG_RAW_IDLE;
      blink <= '0;
    end else if (wr_fire && (32'(wr_addr) < 32'(DIGITS))) begin
      pat[wr_addr]   <= wr_data;
      blink[wr_addr] <= wr_blink;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: slot-position model checked every cycle plus directed literal checks.
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4, SCAN_DIV = 4, BLANK_CYCLES = 2, BLINK_DIV = 16;
  localparam int SLOT = 1 + SCAN_DIV + BLANK_CYCLES;

  logic       clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic       wr_valid = 1'b0, wr_blink = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [6:0] wr_data = '0;
  logic       wr_ready;
  logic [6:0] seg_raw;
  logic [3:0] dig_sel;
  logic [1:0] cur_digit;

  int total = 0, bad = 0;
  int s = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_blink(wr_blink),
    .seg_raw(seg_raw), .dig_sel(dig_sel), .cur_digit(cur_digit)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a position within a 7-cycle slot (0 = load, 1..4 lit, 5..6 dark),
  // blink phase from the cycle count since reset.
  logic [6:0] m_pat [DIGITS];
  bit         m_blink [DIGITS];
  bit         m_on, m_hide, m_ready, m_phase;
  int         m_pos, m_cur, m_cyc;
  logic [6:0] m_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) begin m_pat[i] = 7'h7F; m_blink[i] = 1'b0; end
      m_on = 0; m_hide = 0; m_pos = 0; m_cur = 0; m_cyc = 0; m_seg = 7'h7F;
    end else begin
      m_ready = !(m_on && m_pos == 0);
      m_phase = ((m_cyc / BLINK_DIV) % 2) == 1;
      if (wr_valid && m_ready && int'(wr_addr) < DIGITS) begin
        m_pat[wr_addr]   = wr_data;
        m_blink[wr_addr] = wr_blink;
      end
      if (!en) m_on = 0;
      else if (!m_on) begin m_on = 1; m_pos = 0; end
      else begin
        if (m_pos == 0) begin m_seg = m_pat[m_cur]; m_hide = m_blink[m_cur] && m_phase; end
        if (m_pos == SLOT - 1) begin m_pos = 0; m_cur = (m_cur + 1) % DIGITS; end
        else m_pos++;
      end
      m_cyc++;
    end
  end

  always @(posedge clk) if (!rst && wr_valid && wr_ready) hs_cnt++;

  logic [3:0] e_dig, one;
  always @(negedge clk) begin
    one   = 4'b0001 << m_cur;
    e_dig = (m_on && m_pos >= 1 && m_pos <= SCAN_DIV && !m_hide) ? ~one : 4'hF;
    check("dig_sel", dig_sel, e_dig);
    check("seg_raw", seg_raw, m_seg);
    check("wr_ready", wr_ready, !rst && !(m_on && m_pos == 0));
    check("cur_digit", cur_digit, m_cur);
  end

  task automatic step();
    @(posedge clk); #2; s++;
  endtask

  task automatic goto(input int d, input int p);
    int n = 0;
    do begin step(); n++; end
    while (!(((s - 1) % SLOT) == p && (((s - 1) / SLOT) % DIGITS) == d) && n < 200);
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL goto_timeout: digit %0d pos %0d not reached", d, p);
    end
  endtask

  logic [6:0] pats [4] = '{7'h27, 7'h33, 7'h1D, 7'h16};
  int seen_hide = 0, seen_show = 0;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_dig", dig_sel, 4'hF);
    check("rst_seg", seg_raw, 7'h7F);
    check("rst_ready", wr_ready, 0);
    check("rst_cur", cur_digit, 0);
    rst = 0;
    @(posedge clk); #2;
    check("off_ready", wr_ready, 1);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_addr = 2'(i); wr_data = pats[i];
      @(posedge clk); #2;
    end
    wr_valid = 0;

    // scan sequence and wrap
    en = 1; s = 0;
    step();
    check("load_ready", wr_ready, 0);
    check("load_dig", dig_sel, 4'hF);
    step();
    check("d0_dig", dig_sel, 4'b1110);
    check("d0_seg", seg_raw, 7'h27);
    goto(0, 4);
    check("d0_last_dig", dig_sel, 4'b1110);
    step();
    check("blank_dig", dig_sel, 4'hF);
    goto(1, 1);
    check("d1_dig", dig_sel, 4'b1101);
    check("d1_seg", seg_raw, 7'h33);
    check("d1_cur", cur_digit, 1);
    goto(0, 1);
    check("wrap_dig", dig_sel, 4'b1110);
    check("wrap_seg", seg_raw, 7'h27);

    // rewrite of the lit digit
    goto(2, 1);
    wr_valid = 1; wr_addr = 2; wr_data = 7'h07; wr_blink = 0;
    step();
    wr_valid = 0;
    check("notear_seg", seg_raw, 7'h1D);
    goto(2, 4);
    check("notear_end_seg", seg_raw, 7'h1D);
    goto(2, 1);
    check("newpat_seg", seg_raw, 7'h07);
    check("newpat_dig", dig_sel, 4'b1011);

    // write stalled by a load cycle
    goto(0, 0);
    hs_cnt = 0;
    wr_valid = 1; wr_addr = 1; wr_data = 7'h5A;
    check("stall_ready", wr_ready, 0);
    step();
    check("after_stall_ready", wr_ready, 1);
    step();
    wr_valid = 0;
    check("one_accept", hs_cnt, 1);
    goto(1, 1);
    check("stall_write_seg", seg_raw, 7'h5A);

    // blinking digit 1
    goto(1, 2);
    wr_valid = 1; wr_addr = 1; wr_data = 7'h33; wr_blink = 1;
    step();
    wr_valid = 0; wr_blink = 0;
    for (int k = 0; k < 8; k++) begin
      goto(1, 1);
      if (dig_sel == 4'hF) seen_hide++;
      else if (dig_sel == 4'b1101) seen_show++;
    end
    check("blink_hidden_seen", seen_hide > 0, 1);
    check("blink_shown_seen", seen_show > 0, 1);
    goto(0, 1);
    check("blink_other_dig", dig_sel, 4'b1110);

    // enable drop and resume
    goto(3, 2);
    en = 0;
    step();
    check("en_off_dig", dig_sel, 4'hF);
    check("en_off_cur", cur_digit, 3);
    step(); step();
    check("en_hold_cur", cur_digit, 3);
    en = 1;
    step();
    check("resume_load_ready", wr_ready, 0);
    check("resume_cur", cur_digit, 3);
    s = 1 + SLOT * 3;
    step();
    check("resume_dig", dig_sel, 4'b0111);
    check("resume_seg", seg_raw, 7'h16);

    // asynchronous reset mid-slot
    goto(2, 2);
    rst = 1;
    #1;
    check("arst_dig", dig_sel, 4'hF);
    check("arst_seg", seg_raw, 7'h7F);
    check("arst_ready", wr_ready, 0);
    check("arst_cur", cur_digit, 0);
    @(posedge clk); #2;
    rst = 0; s = 0;
    step();
    step();
    check("post_rst_seg0", seg_raw, 7'h7F);
    check("post_rst_dig0", dig_sel, 4'b1110);
    goto(1, 1);
    check("post_rst_seg1", seg_raw, 7'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
